// File: rtl/pit_pkg.sv
// Shared types and divisor maps for the PIT prescaler.
// end_count() turns a 4-bit divisor code into the terminal count of a
// channel's div-N counter, clamped to the counter's width.
package pit_pkg;

   typedef logic [3:0] div_code_t;

   localparam logic [31:0] DECADE_MAP [16] = '{
      32'd1,     32'd2,     32'd4,     32'd8,
      32'd10,    32'd100,   32'd1000,  32'd10000,
      32'd20000, 32'd20000, 32'd20000, 32'd20000,
      32'd20000, 32'd20000, 32'd20000, 32'd20000
   };

   localparam logic [31:0] BINARY_MAP [16] = '{
      32'd1,     32'd2,     32'd4,     32'd8,
      32'd16,    32'd32,    32'd64,    32'd128,
      32'd256,   32'd512,   32'd1024,  32'd2048,
      32'd4096,  32'd8192,  32'd16384, 32'd32768
   };

   // count_size must lie in 4..32; the result never exceeds 2^count_size-1.
   function automatic logic [31:0] end_count(input div_code_t code,
                                             input int        decade,
                                             input int        count_size);
      logic [31:0] raw_s;
      logic [32:0] max_s;
      if (decade != 0) begin
         raw_s = DECADE_MAP[code];
      end else begin
         raw_s = BINARY_MAP[code];
      end
      max_s = (33'd1 << count_size) - 33'd1;
      if ({1'b0, raw_s} > max_s) begin
         raw_s = max_s[31:0];
      end else begin
         raw_s = raw_s;
      end
      return raw_s;
   endfunction

endpackage

// File: rtl/pit_prescale_mc_if.sv
// Register-file side bundle of the multi-channel prescaler.
// master = register file / PIT control, slave = prescaler.
interface pit_prescale_mc_if #(
   parameter int CHANNELS = 2
);
   logic                    cnt_sync_o;
   logic                    ext_sync_i;
   logic                    pit_slave;
   logic [4*CHANNELS-1:0]   divisor;
   logic [CHANNELS-1:0]     div_load;
   logic                    counter_sync;
   logic [CHANNELS-1:0]     prescale_out;
   logic [CHANNELS-1:0]     div_pending;

   modport master (
      output cnt_sync_o, ext_sync_i, pit_slave, divisor, div_load,
      input  counter_sync, prescale_out, div_pending
   );

   modport slave (
      input  cnt_sync_o, ext_sync_i, pit_slave, divisor, div_load,
      output counter_sync, prescale_out, div_pending
   );
endinterface

// File: rtl/pit_prescale_chan.sv
// One prescale channel: active/shadow divisor, pending flag and div-N
// counter. A divisor written while the channel is mid-period is parked in
// the shadow register and only takes effect at the next rollover (or as
// soon as counting stops), so a running period is never cut short.
module pit_prescale_chan
   import pit_pkg::*;
#(
   parameter int COUNT_SIZE  = 16,
   parameter int DECADE_CNTR = 1
) (
   input  logic      bus_clk,
   input  logic      sync_reset,
   input  logic      counter_sync,
   input  div_code_t div_code,
   input  logic      div_load,
   output logic      tick,
   output logic      pending
);

   localparam logic [COUNT_SIZE-1:0] CNT_ONE = COUNT_SIZE'(1);

   div_code_t             act_div_r;
   div_code_t             shd_div_r;
   logic                  pend_r;
   logic [COUNT_SIZE-1:0] cnt_n_r;

   logic [31:0] end_cnt_s;
   logic [31:0] cnt_ext_s;
   logic        rollover_s;
   logic        apply_s;

   // Terminal count of the active divisor, rollover and "safe to switch" flag
   always_comb begin
      end_cnt_s  = end_count(act_div_r, DECADE_CNTR, COUNT_SIZE);
      cnt_ext_s  = 32'(cnt_n_r);
      rollover_s = (cnt_ext_s == end_cnt_s);
      apply_s    = !counter_sync || rollover_s;
   end

   // Divisor shadow/apply bookkeeping and the div-N counter
   always_ff @(posedge bus_clk) begin
      if (sync_reset) begin
         act_div_r <= 4'd0;
         shd_div_r <= 4'd0;
         pend_r    <= 1'b0;
         cnt_n_r   <= CNT_ONE;
      end else begin
         if (div_load && apply_s) begin
            act_div_r <= div_code;
            pend_r    <= 1'b0;
         end else if (div_load) begin
            shd_div_r <= div_code;
            pend_r    <= 1'b1;
         end else if (apply_s && pend_r) begin
            act_div_r <= shd_div_r;
            pend_r    <= 1'b0;
         end else begin
            act_div_r <= act_div_r;
            pend_r    <= pend_r;
         end
         if (!counter_sync || rollover_s) begin
            cnt_n_r <= CNT_ONE;
         end else begin
            cnt_n_r <= cnt_n_r + CNT_ONE;
         end
      end
   end

   // Tick is combinational so a divide-by-1 channel passes the enable through
   always_comb begin
      tick    = !sync_reset && counter_sync && rollover_s;
      pending = pend_r;
   end

endmodule

// File: rtl/pit_prescale_mc.sv
// Multi-channel PIT prescaler: selects the master or slave counter enable
// and fans it out to CHANNELS independent prescale channels.
module pit_prescale_mc
   import pit_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int COUNT_SIZE  = 16,
   parameter int DECADE_CNTR = 1
) (
   input  logic                bus_clk,
   input  logic                sync_reset,
   pit_prescale_mc_if.slave    bus
);

   logic                counter_sync_s;
   logic [CHANNELS-1:0] tick_s;
   logic [CHANNELS-1:0] pend_s;

   // Enable source: external PIT in slave mode, local enable otherwise
   always_comb begin
      if (bus.pit_slave) begin
         counter_sync_s = bus.ext_sync_i;
      end else begin
         counter_sync_s = bus.cnt_sync_o;
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      pit_prescale_chan #(
         .COUNT_SIZE  (COUNT_SIZE),
         .DECADE_CNTR (DECADE_CNTR)
      ) u_chan (
         .bus_clk      (bus_clk),
         .sync_reset   (sync_reset),
         .counter_sync (counter_sync_s),
         .div_code     (bus.divisor[4*gi +: 4]),
         .div_load     (bus.div_load[gi]),
         .tick         (tick_s[gi]),
         .pending      (pend_s[gi])
      );
   end

   assign bus.counter_sync = counter_sync_s;
   assign bus.prescale_out = tick_s;
   assign bus.div_pending  = pend_s;

endmodule

// File: tb/tb_pit_prescale_mc.sv
// Bench for pit_prescale_mc. Two instances share one stimulus stream:
//   dut_a : COUNT_SIZE=16, decade map
//   dut_b : COUNT_SIZE=8,  binary map (exercises the end-count clamp)
// A per-channel model tracks divisor in use, pending shadow and how many
// enable cycles of the current period have elapsed; every cycle the
// outputs of both instances are compared against it.
module tb_pit_prescale_mc;

   localparam int DEC [2] = '{1, 0};
   localparam int CSZ [2] = '{16, 8};

   logic       bus_clk;
   logic       sync_reset;
   logic       cnt_sync_o;
   logic       ext_sync_i;
   logic       pit_slave;
   logic [7:0] divisor;
   logic [1:0] div_load;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   int m_act   [2][2];
   int m_shd   [2][2];
   int m_pend  [2][2];
   int m_phase [2][2];

   pit_prescale_mc_if #(.CHANNELS(2)) ifa ();
   pit_prescale_mc_if #(.CHANNELS(2)) ifb ();

   assign ifa.cnt_sync_o = cnt_sync_o;
   assign ifa.ext_sync_i = ext_sync_i;
   assign ifa.pit_slave  = pit_slave;
   assign ifa.divisor    = divisor;
   assign ifa.div_load   = div_load;
   assign ifb.cnt_sync_o = cnt_sync_o;
   assign ifb.ext_sync_i = ext_sync_i;
   assign ifb.pit_slave  = pit_slave;
   assign ifb.divisor    = divisor;
   assign ifb.div_load   = div_load;

   logic [1:0] po [2];
   logic [1:0] dp [2];
   logic       cs [2];
   assign po[0] = ifa.prescale_out;
   assign po[1] = ifb.prescale_out;
   assign dp[0] = ifa.div_pending;
   assign dp[1] = ifb.div_pending;
   assign cs[0] = ifa.counter_sync;
   assign cs[1] = ifb.counter_sync;

   pit_prescale_mc #(.CHANNELS(2), .COUNT_SIZE(16), .DECADE_CNTR(1)) dut_a (
      .bus_clk    (bus_clk),
      .sync_reset (sync_reset),
      .bus        (ifa)
   );

   pit_prescale_mc #(.CHANNELS(2), .COUNT_SIZE(8), .DECADE_CNTR(0)) dut_b (
      .bus_clk    (bus_clk),
      .sync_reset (sync_reset),
      .bus        (ifb)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   // Divisor code to period length, straight from the divisor tables
   function automatic int ref_end(input int code, input int decade, input int csz);
      int v;
      int lim;
      if (decade != 0) begin
         case (code)
            0: v = 1;
            1: v = 2;
            2: v = 4;
            3: v = 8;
            4: v = 10;
            5: v = 100;
            6: v = 1000;
            7: v = 10000;
            default: v = 20000;
         endcase
      end else begin
         v = 1 << code;
      end
      lim = (1 << csz) - 1;
      if (v > lim) v = lim;
      return v;
   endfunction

   task automatic pin(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge bus_clk);
      #1;
   endtask

   // Model: advance each channel by one clock
   initial begin
      int en, e, code;
      bit roll, ap, ld;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 2; c++) begin
            m_act[d][c] = 0; m_shd[d][c] = 0; m_pend[d][c] = 0; m_phase[d][c] = 0;
         end
      forever begin
         @(posedge bus_clk);
         en = pit_slave ? int'(ext_sync_i) : int'(cnt_sync_o);
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
               e    = ref_end(m_act[d][c], DEC[d], CSZ[d]);
               roll = (m_phase[d][c] + 1 == e);
               ap   = (en == 0) || roll;
               ld   = div_load[c];
               code = int'(divisor[4*c +: 4]);
               if (sync_reset) begin
                  m_act[d][c] = 0; m_shd[d][c] = 0; m_pend[d][c] = 0; m_phase[d][c] = 0;
               end else begin
                  if (ld && ap) begin
                     m_act[d][c] = code; m_pend[d][c] = 0;
                  end else if (ld) begin
                     m_shd[d][c] = code; m_pend[d][c] = 1;
                  end else if (ap && m_pend[d][c] != 0) begin
                     m_act[d][c] = m_shd[d][c]; m_pend[d][c] = 0;
                  end
                  if (en != 0 && !roll) m_phase[d][c] = m_phase[d][c] + 1;
                  else m_phase[d][c] = 0;
               end
            end
         end
      end
   end

   // Compare both instances against the model every cycle
   initial begin
      int en, e, exp_t;
      forever begin
         @(negedge bus_clk);
         if (chk_on) begin
            en = pit_slave ? int'(ext_sync_i) : int'(cnt_sync_o);
            for (int d = 0; d < 2; d++) begin
               pin($sformatf("counter_sync dut%0d", d), int'(cs[d]), en);
               for (int c = 0; c < 2; c++) begin
                  e     = ref_end(m_act[d][c], DEC[d], CSZ[d]);
                  exp_t = (!sync_reset && en != 0 && m_phase[d][c] + 1 == e) ? 1 : 0;
                  pin($sformatf("prescale_out dut%0d ch%0d", d, c), int'(po[d][c]), exp_t);
                  pin($sformatf("div_pending dut%0d ch%0d", d, c), int'(dp[d][c]), m_pend[d][c]);
               end
            end
         end
      end
   end

   // Stimulus with hand-computed expectations on dut_a / dut_b
   initial begin
      bit [3:0] pat;
      sync_reset = 1'b1; cnt_sync_o = 1'b1; ext_sync_i = 1'b0; pit_slave = 1'b0;
      divisor = 8'h00; div_load = 2'b00;
      cyc();
      chk_on = 1'b1;
      @(negedge bus_clk);
      pin("reset prescale_out", int'(po[0]), 0);
      cyc();

      // divide-by-1 after reset: pass-through of the enable
      sync_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge bus_clk);
         pin("div1 all ticking", int'(po[0]), 3);
         cyc();
      end
      cnt_sync_o = 1'b0;
      @(negedge bus_clk);
      pin("div1 enable drop", int'(po[0]), 0);

      // ch0 /4, ch1 decade /10
      cyc();
      divisor = {4'd4, 4'd2}; div_load = 2'b11;
      cyc();
      div_load = 2'b00; cnt_sync_o = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge bus_clk);
         pin("ch0 div4 tick", int'(po[0][0]), (k == 3 || k == 7 || k == 11 || k == 15 || k == 19) ? 1 : 0);
         pin("ch1 div10 tick", int'(po[0][1]), (k == 9 || k == 19) ? 1 : 0);
         cyc();
      end

      // ch0 /100 with a deferred load, loads at rollover, double load
      cnt_sync_o = 1'b0; divisor = {4'd4, 4'd5}; div_load = 2'b01;
      cyc();
      div_load = 2'b00; cnt_sync_o = 1'b1;
      for (int k = 0; k < 125; k++) begin
         div_load = 2'b00;
         case (k)
            39:  begin divisor[3:0] = 4'd1; div_load = 2'b01; end
            105: begin divisor[3:0] = 4'd2; div_load = 2'b01; end
            110: begin divisor[3:0] = 4'd3; div_load = 2'b01; end
            111: begin divisor[3:0] = 4'd4; div_load = 2'b01; end
            default: ;
         endcase
         @(negedge bus_clk);
         if (k == 39)  pin("pend before rise", int'(dp[0][0]), 0);
         if (k == 40)  pin("pend rises", int'(dp[0][0]), 1);
         if (k == 98)  pin("old period no tick", int'(po[0][0]), 0);
         if (k == 99)  begin pin("div100 rollover tick", int'(po[0][0]), 1); pin("pend at apply", int'(dp[0][0]), 1); end
         if (k == 100) begin pin("div2 first cycle", int'(po[0][0]), 0); pin("pend falls", int'(dp[0][0]), 0); end
         if (k == 101) pin("div2 tick", int'(po[0][0]), 1);
         if (k == 106) pin("rollover load no pend", int'(dp[0][0]), 0);
         if (k == 109) pin("div4 tick", int'(po[0][0]), 1);
         if (k == 112) pin("double load pend", int'(dp[0][0]), 1);
         if (k == 113) pin("div4 second tick", int'(po[0][0]), 1);
         if (k == 114) pin("double load applied", int'(dp[0][0]), 0);
         if (k == 117) pin("not div4", int'(po[0][0]), 0);
         if (k == 121) pin("not div8", int'(po[0][0]), 0);
         if (k == 123) pin("div10 tick", int'(po[0][0]), 1);
         cyc();
      end

      // slave pass-through
      div_load = 2'b00;
      pit_slave = 1'b1; ext_sync_i = 1'b0; divisor = 8'h00; div_load = 2'b11;
      cyc();
      div_load = 2'b00; cnt_sync_o = 1'b0;
      pat = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         ext_sync_i = pat[k];
         cnt_sync_o = ~pat[k];
         @(negedge bus_clk);
         pin("slave counter_sync", int'(cs[0]), int'(pat[k]));
         pin("slave prescale_out0", int'(po[0][0]), int'(pat[k]));
         cyc();
      end

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         sync_reset = ($urandom_range(0, 199) == 0);
         cnt_sync_o = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) pit_slave = ~pit_slave;
         ext_sync_i = ($urandom_range(0, 4) != 0);
         for (int c = 0; c < 2; c++) begin
            div_load[c] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) divisor[4*c +: 4] = 4'($urandom_range(0, 15));
            else divisor[4*c +: 4] = 4'($urandom_range(0, 5));
         end
         cyc();
      end

      // clamp: binary code 10 on an 8-bit counter gives period 255
      sync_reset = 1'b1; div_load = 2'b00; pit_slave = 1'b0; cnt_sync_o = 1'b0;
      cyc();
      sync_reset = 1'b0; divisor = {4'd10, 4'd10}; div_load = 2'b11;
      cyc();
      div_load = 2'b00; cnt_sync_o = 1'b1;
      for (int k = 0; k < 357; k++) begin
         div_load = 2'b00;
         sync_reset = (k == 354);
         if (k == 300) begin divisor[3:0] = 4'd3; div_load = 2'b01; end
         @(negedge bus_clk);
         if (k < 300)  pin("clamp 255 tick", int'(po[1][0]), (k == 254) ? 1 : 0);
         if (k == 301) pin("clamp pend rises", int'(dp[1][0]), 1);
         if (k == 353) pin("clamp pend held", int'(dp[1][0]), 1);
         if (k == 354) pin("reset mid-count no tick", int'(po[1]), 0);
         if (k == 355) begin
            pin("after reset div1", int'(po[1]), 3);
            pin("after reset pend cleared", int'(dp[1]), 0);
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pit_prescale_mc.md
# pit_prescale_mc

Multi-channel prescaler for the PIT. It generates one prescale tick stream per channel from a shared counter enable. Each channel has its own 4-bit divisor code and a shadow divisor register, so a divisor written mid-count only takes effect at the channel's next rollover or while counting is idle. It sits between the PIT register file and the PIT counters, and supports master/slave sync chaining.

## Interface
Parameters:
- CHANNELS, 2: number of independent prescale channels (1..8).
- COUNT_SIZE, 16: width of each channel's div-N counter (≥4).
- DECADE_CNTR, 1: 1 selects the decade divisor map, 0 selects the binary map.

Ports:
- bus_clk  in  1  reference clock; all logic on its rising edge.
- sync_reset  in  1  reset, synchronous, active-high.
- cnt_sync_o  in  1  local counter enable (master mode).
- ext_sync_i  in  1  enable from external PIT (slave mode).
- pit_slave  in  1  1 = use ext_sync_i as enable.
- divisor  in  4*CHANNELS  divisor code; channel i uses bits [4i+3:4i].
- div_load  in  CHANNELS  one-cycle strobe: capture divisor code for channel i.
- counter_sync  out  1  selected enable: pit_slave ? ext_sync_i : cnt_sync_o.
- prescale_out  out  CHANNELS  per-channel tick; high for exactly the rollover cycle.
- div_pending  out  CHANNELS  shadow divisor captured, not yet applied.

## Operation
- Divisor maps (code → end_count):
  - Decade: 0→1, 1→2, 2→4, 3→8, 4→10, 5→100, 6→1000, 7→10000, 8..15→20000.
  - Binary: code n → 2^n.
  - Any end_count > 2^COUNT_SIZE−1 is clamped to 2^COUNT_SIZE−1.
- Per-channel state:
  - act_div (4b): the code in use.
  - shd_div (4b): shadow code.
  - pend (1b): drives div_pending.
  - cnt_n (COUNT_SIZE): div-N counter.
- rollover[i] = (cnt_n == end_count(act_div)).
- apply[i] = !counter_sync || (counter_sync && rollover[i]).
- Divisor update priority, evaluated per cycle:
  1. div_load && apply: act_div ← divisor[i]; pend ← 0.
  2. div_load && !apply: shd_div ← divisor[i]; pend ← 1. A later div_load overwrites shd_div.
  3. !div_load && apply && pend: act_div ← shd_div; pend ← 0.
  4. Otherwise hold.
- Counter: if !counter_sync or rollover, cnt_n ← 1; else cnt_n ← cnt_n + 1.
- prescale_out[i] = !sync_reset && counter_sync && rollover[i].
  - With end_count 1, prescale_out equals counter_sync, which gives slave pass-through of ext_sync_i.
- Channels are fully independent; all share counter_sync.

## Timing
- Reset values: cnt_n=1, act_div=0, shd_div=0, pend=0 in all channels. prescale_out=0 while sync_reset is high.
- After reset, act_div=0 (÷1): prescale_out[i] follows counter_sync combinationally.
- For end_count N ≥ 2, counting from the first cycle counter_sync is high (cnt_n=1):
  - First tick is in enable cycle N.
  - Subsequent ticks every N cycles.
  - prescale_out has zero latency from cnt_n; it is combinational from registers and counter_sync.
- Dropping counter_sync zeroes prescale_out that cycle and returns cnt_n to 1 on the next edge. Re-enable restarts a full period.
- A new divisor applied at a rollover governs the very next period. The tick in the rollover cycle belongs to the old divisor.
- div_pending rises the cycle after a deferred div_load and falls the cycle after apply.
- Reset mid-count takes priority over everything, including div_load: all state returns to reset values on the next edge.
- Flipping pit_slave while counting changes counter_sync immediately. No extra protection is provided.

## Structure
- Package pit_pkg holds:
  - Divisor code typedef (logic [3:0]).
  - Decade and binary end_count constant arrays.
  - Function end_count(code, DECADE_CNTR, COUNT_SIZE), which includes the clamp.
- Sub-module pit_prescale_chan: one channel (shadow/active divisor, pend, cnt_n, rollover). The top level generates CHANNELS instances and the counter_sync mux.

## Test plan
- Reset, then cnt_sync_o=1, pit_slave=0, both divisors 0 → prescale_out=2'b11 every cycle; drop cnt_sync_o → 2'b00 the same cycle.
- Channel 0 code 2 (÷4), channel 1 code 4 (decade ÷10), enable at cycle 0 → ch0 ticks at cycles 3, 7, 11; ch1 ticks at cycles 9, 19.
- Ch0 running ÷100 (code 5); at cnt_n=40 load code 1 → div_pending[0]=1 until the rollover at cnt_n=100, then ticks every 2 cycles; div_pending[0]=0.
- div_load coinciding with a rollover cycle → new code applied directly; div_pending never rises. Two loads before rollover → only the second code is applied.
- pit_slave=1, code 0, ext_sync_i pulsed 1,0,1,1 → prescale_out[0] and counter_sync mirror 1,0,1,1; cnt_sync_o ignored.
- COUNT_SIZE=8, binary code 10 → end_count clamped to 255; tick period 255. Assert sync_reset at cnt_n=100 → cnt_n=1, act_div=0, pending cleared next cycle.
